// File: rtl/board_scanner_if.sv
// board_scanner_if: matrix and move-event bundle between the reed-switch scanner and the game logic.
//   enable        scanning runs while high
//   rows_in       row sense lines, active-low
//   col_drive     column drive, active-low one-hot, 8'hFF when idle
//   jogadaFileira row of the last event, 1..8
//   jogadaColuna  column of the last event, 0..7
//   temJogada     one-cycle move pulse
//   db_frame      one-cycle pulse at each frame compare
//   db_estado     current FSM state code
// master: the scanner. slave: the surrounding system.
interface board_scanner_if;
    localparam int unsigned LINES_W = 8;
    localparam int unsigned COORD_W = 4;
    localparam int unsigned STATE_W = 4;

    logic                 enable;
    logic [LINES_W-1:0]   rows_in;
    logic [LINES_W-1:0]   col_drive;
    logic [COORD_W-1:0]   jogadaFileira;
    logic [COORD_W-1:0]   jogadaColuna;
    logic                 temJogada;
    logic                 db_frame;
    logic [STATE_W-1:0]   db_estado;

    modport master (
        input  enable, rows_in,
        output col_drive, jogadaFileira, jogadaColuna, temJogada, db_frame, db_estado
    );

    modport slave (
        output enable, rows_in,
        input  col_drive, jogadaFileira, jogadaColuna, temJogada, db_frame, db_estado
    );
endinterface

// File: rtl/board_scanner.sv
// board_scanner: scans the 8x8 reed-switch matrix column by column, debounces
// over two frames and reports each newly placed piece as one move event.
// Ports:
//   clock  system clock, rising edge
//   reset  synchronous, active-low
//   bus    board_scanner_if.master (enable, rows_in, col_drive, jogada*, db_*)
// Parameter SETTLE (2..15): cycles each column is driven before sampling.
// Optional macro BOARD_INIT_EN: absorb the starting position instead of
// reporting every occupied square after reset.
module board_scanner #(
    parameter int unsigned SETTLE = 4
) (
    input  logic             clock,
    input  logic             reset,
    board_scanner_if.master  bus
);
    localparam int unsigned NSQ    = 64;
    localparam int unsigned COL_W  = 3;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned LINE_W = 8;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_DRIVE   = 4'd1,
        S_NEXT    = 4'd2,
        S_COMPARE = 4'd3,
        S_EMIT    = 4'd4
    } state_t;

    state_t              r_state, w_state_nx;
    logic [NSQ-1:0]      r_cur, r_prev, r_image;
    logic [COL_W-1:0]    r_col, w_col_nx;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
    logic [LINE_W-1:0]   r_col_drive;
    logic [3:0]          r_fileira, r_coluna, r_estado;
    logic                r_tem, r_frame;

    logic [NSQ-1:0]      w_stable_occ, w_stable_emp, w_new, w_new_low;
    logic [IDX_W-1:0]    w_idx;
    logic                w_has_new, w_capture, w_event, w_init_load;

    // Frame debounce: a square is settled only when two consecutive frames agree
    always_comb begin
        w_stable_occ = r_cur & r_prev;
        w_stable_emp = ~r_cur & ~r_prev;
        w_new        = w_stable_occ & ~r_image;
        w_has_new    = |w_new;
        w_new_low    = w_new & (~w_new + 64'd1);
        w_idx        = '0;
        for (int i = NSQ - 1; i >= 0; i--) begin
            if (w_new[i]) w_idx = IDX_W'(i);
        end
    end

`ifdef BOARD_INIT_EN
    logic r_init_done, r_prev_valid;
    // Until the first two-frame compare, the whole stable board is absorbed silently
    assign w_init_load = !r_init_done;
`else
    assign w_init_load = 1'b0;
`endif

    assign w_event = (r_state == S_COMPARE) && w_has_new && !w_init_load;

    // State register
    always_ff @(posedge clock) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    // Next-state, column pointer and settle counter
    always_comb begin
        w_state_nx = r_state;
        w_col_nx   = r_col;
        w_cnt_nx   = r_cnt;
        w_capture  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_col_nx = '0;
                w_cnt_nx = '0;
                if (bus.enable) w_state_nx = S_DRIVE;
            end
            S_DRIVE: begin
                if (!bus.enable) begin
                    w_state_nx = S_IDLE;
                    w_col_nx   = '0;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(SETTLE - 1)) begin
                        w_capture  = 1'b1;
                        w_state_nx = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                w_cnt_nx = '0;
                if (!bus.enable) begin
                    w_state_nx = S_IDLE;
                    w_col_nx   = '0;
                end else if (r_col == COL_W'(7)) begin
                    w_state_nx = S_COMPARE;
                end else begin
                    w_col_nx   = r_col + COL_W'(1);
                    w_state_nx = S_DRIVE;
                end
            end
            S_COMPARE, S_EMIT: begin
                w_col_nx = '0;
                w_cnt_nx = '0;
                if (w_event)          w_state_nx = S_EMIT;
                else if (bus.enable)  w_state_nx = S_DRIVE;
                else                  w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
                w_col_nx   = '0;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // Datapath and registered outputs; outputs follow the state being entered
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cur       <= '0;
            r_prev      <= '0;
            r_image     <= '0;
            r_col       <= '0;
            r_cnt       <= '0;
            r_col_drive <= 8'hFF;
            r_fileira   <= '0;
            r_coluna    <= '0;
            r_tem       <= 1'b0;
            r_frame     <= 1'b0;
            r_estado    <= '0;
`ifdef BOARD_INIT_EN
            r_init_done  <= 1'b0;
            r_prev_valid <= 1'b0;
`endif
        end else begin
            r_col <= w_col_nx;
            r_cnt <= w_cnt_nx;
            if (w_capture) r_cur[{r_col, 3'b000} +: LINE_W] <= ~bus.rows_in;
            if (r_state == S_COMPARE) begin
                r_prev <= r_cur;
                if (w_init_load) r_image <= w_stable_occ;
                else             r_image <= (r_image & ~w_stable_emp) | w_new_low;
`ifdef BOARD_INIT_EN
                if (!r_init_done) begin
                    r_init_done  <= r_prev_valid;
                    r_prev_valid <= 1'b1;
                end
`endif
            end
            if (w_event) begin
                r_fileira <= 4'(w_idx[2:0]) + 4'd1;
                r_coluna  <= 4'(w_idx[5:3]);
            end
            r_tem       <= w_event;
            r_frame     <= (w_state_nx == S_COMPARE);
            r_estado    <= w_state_nx;
            r_col_drive <= (w_state_nx == S_DRIVE) ? ~(8'd1 << w_col_nx) : 8'hFF;
        end
    end

    assign bus.col_drive     = r_col_drive;
    assign bus.jogadaFileira = r_fileira;
    assign bus.jogadaColuna  = r_coluna;
    assign bus.temJogada     = r_tem;
    assign bus.db_frame      = r_frame;
    assign bus.db_estado     = r_estado;
endmodule

// File: tb/tb_board_scanner.sv
// Directed bench for board_scanner (SETTLE=2): a physical board model answers
// the column drive, expected move events are queued when pieces are placed
// and popped when temJogada pulses.
module tb_board_scanner;
    typedef struct packed {
        logic [3:0] col;
        logic [3:0] fil;
    } ev_t;

    logic clock = 1'b0;
    logic reset;
    logic [63:0] board;
    logic [7:0]  w_rows;

    board_scanner_if bus();

    board_scanner #(.SETTLE(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Reed switches: a piece pulls its row low while its column is driven
    always_comb begin
        w_rows = 8'hFF;
        for (int c = 0; c < 8; c++) begin
            if (!bus.col_drive[c]) w_rows = w_rows & ~board[c*8 +: 8];
        end
    end
    assign bus.rows_in = w_rows;

    int   total = 0;
    int   bad = 0;
    int   frame_cnt = 0;
    logic prev_frame = 1'b0;
    logic prev_tem = 1'b0;
    logic [7:0] prev_cd = 8'hFF;
    ev_t  exp_q[$];
    int   ev_frames[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input int idx);
        ev_t e;
        e.col = 4'(idx / 8);
        e.fil = 4'(idx % 8 + 1);
        exp_q.push_back(e);
    endtask

    // One cycle, sampled on the falling edge, with the running protocol checks
    task automatic tick();
        ev_t e;
        @(negedge clock);
        check("col_onehot", 64'($countones(~bus.col_drive) <= 1), 1);
        if (prev_cd != 8'hFF && bus.col_drive != 8'hFF)
            check("col_break", bus.col_drive, prev_cd);
        if (bus.db_frame) frame_cnt++;
        if (bus.temJogada) begin
            check("tem_after_frame", prev_frame, 1);
            check("tem_gap", prev_tem, 0);
            if (exp_q.size() == 0) begin
                check("spurious_event", bus.temJogada, 0);
            end else begin
                e = exp_q.pop_front();
                check("ev_col", bus.jogadaColuna, e.col);
                check("ev_row", bus.jogadaFileira, e.fil);
            end
            ev_frames.push_back(frame_cnt);
        end
        prev_frame = bus.db_frame;
        prev_tem   = bus.temJogada;
        prev_cd    = bus.col_drive;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.db_frame && n < 200);
        if (!bus.db_frame) check("frame_timeout", bus.db_frame, 1);
    endtask

    task automatic wait_frames(input int k);
        for (int i = 0; i < k; i++) wait_frame();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        check(tag, 64'(exp_q.size()), 0);
    endtask

    initial begin
        int n;
        reset      = 1'b0;
        bus.enable = 1'b0;
`ifdef BOARD_INIT_EN
        board = 64'hC3C3_C3C3_C3C3_C3C3;
`else
        board = '0;
`endif
        repeat (3) begin
            tick();
            check("rst_col_drive", bus.col_drive, 8'hFF);
            check("rst_tem", bus.temJogada, 0);
            check("rst_estado", bus.db_estado, 0);
        end
        reset = 1'b1;
        tick();
        check("idle_estado", bus.db_estado, 0);
        check("idle_fileira", bus.jogadaFileira, 0);
        check("idle_coluna", bus.jogadaColuna, 0);
        bus.enable = 1'b1;
        tick();
        check("first_col", bus.col_drive, 8'hFE);
        check("first_estado", bus.db_estado, 1);

`ifdef BOARD_INIT_EN
        // Starting position absorbed; only the later placement is reported
        wait_frames(5);
        check("init_quiet", 64'(ev_frames.size()), 0);
        wait_frame();
        board[35] = 1'b1;
        push_ev(35);
        drain("drain_init_add");
        wait_frames(3);
`else
        wait_frames(3);

        // Single piece held: one event, then silence while coordinates hold
        wait_frame();
        board[28] = 1'b1;
        push_ev(28);
        drain("drain_single");
        wait_frames(10);
        check("hold_coluna", bus.jogadaColuna, 3);
        check("hold_fileira", bus.jogadaFileira, 5);

        // Two pieces in the same frame: lowest index first, consecutive frames
        ev_frames.delete();
        wait_frame();
        board[22] = 1'b1;
        board[49] = 1'b1;
        push_ev(22);
        push_ev(49);
        drain("drain_pair");
        check("pair_count", 64'(ev_frames.size()), 2);
        if (ev_frames.size() == 2)
            check("pair_gap", 64'(ev_frames[1] - ev_frames[0]), 1);

        // One-frame glitch is ignored
        wait_frame();
        board[0] = 1'b1;
        wait_frame();
        board[0] = 1'b0;
        wait_frames(4);

        // Lift for two frames, replace: reported again
        wait_frame();
        board[28] = 1'b0;
        wait_frames(2);
        board[28] = 1'b1;
        push_ev(28);
        drain("drain_replace");

        // Enable dropped while column 4 is driven
        n = 0;
        while (bus.col_drive != 8'hEF && n < 200) begin
            tick();
            n++;
        end
        check("col4_seen", bus.col_drive, 8'hEF);
        bus.enable = 1'b0;
        tick();
        check("drop_estado", bus.db_estado, 0);
        check("drop_col_drive", bus.col_drive, 8'hFF);
        repeat (3) tick();
        check("drop_stay", bus.db_estado, 0);
        bus.enable = 1'b1;
        tick();
        check("reen_col0", bus.col_drive, 8'hFE);
        wait_frames(4);

        // Reset mid-frame: image cleared, every present piece reported in index order
        repeat (7) tick();
        reset = 1'b0;
        tick();
        check("mid_rst_col_drive", bus.col_drive, 8'hFF);
        check("mid_rst_estado", bus.db_estado, 0);
        check("mid_rst_coluna", bus.jogadaColuna, 0);
        check("mid_rst_fileira", bus.jogadaFileira, 0);
        reset = 1'b1;
        push_ev(22);
        push_ev(28);
        push_ev(49);
        drain("drain_powerup");
        wait_frames(3);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
